// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the register hazard scoreboard: parameter defaults,
// hazard_src bit positions and the per-register scoreboard entry payload.
package hazard_scoreboard_pkg;

    localparam int unsigned DEF_REG_ADDR_W   = 5;
    localparam int unsigned DEF_ALU_LAT      = 2;
    localparam int unsigned DEF_LD_LAT       = 3;
    localparam int unsigned DEF_LD_USE_STALL = 1;
    localparam int unsigned DEF_CNT_W        = 3;

    // Entry countdown field is sized for the widest supported CNT_W;
    // narrower countdowns are zero-extended into it.
    localparam int unsigned SB_CNT_MAX_W     = 8;

    localparam int unsigned STALL_CNT_W      = 16;

    // hazard_src bit positions
    localparam int unsigned HSRC_SRC1        = 0;
    localparam int unsigned HSRC_SRC2        = 1;

    typedef struct packed {
        logic [SB_CNT_MAX_W-1:0] cnt;
        logic                    ld;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: countdown of cycles until the pending register-file
// write lands, plus a flag recording whether that write comes from a load.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT,
    parameter int unsigned LD_LAT  = DEF_LD_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  logic      i_is_ld,
    output sb_entry_t o_entry
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ld;

    // New issue reloads the countdown (newest writer wins), otherwise count down to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ld  <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_is_ld ? CNT_W'(LD_LAT) : CNT_W'(ALU_LAT);
            r_ld  <= i_is_ld;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_entry.cnt = SB_CNT_MAX_W'(r_cnt);
    assign o_entry.ld  = r_ld;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for an in-order pipeline ID stage: tracks pending
// register-file writes and stalls ID on RAW conflicts, accounting for the
// forwarding network and load-use latency.
// Optional feature: define HAZARD_STATS_EN to enable the saturating stall_cnt
// counter; otherwise stall_cnt is tied to 0.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int unsigned ALU_LAT      = DEF_ALU_LAT,
    parameter int unsigned LD_LAT       = DEF_LD_LAT,
    parameter int unsigned LD_USE_STALL = DEF_LD_USE_STALL,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  src1_ID,
    input  logic [REG_ADDR_W-1:0]  src2_ID,
    input  logic                   is_imm,
    input  logic                   ST_or_BNE,
    input  logic [REG_ADDR_W-1:0]  dest_ID,
    input  logic                   WB_EN_ID,
    input  logic                   MEM_R_EN_ID,
    input  logic                   forward_EN,
    input  logic                   flush,
    output logic                   hazard_detected,
    output logic [1:0]             hazard_src,
    output logic                   issue_fire,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned NREG       = 1 << REG_ADDR_W;
    localparam int unsigned LD_FWD_THR = LD_LAT - LD_USE_STALL;

    // Reject configurations whose latencies do not fit the countdown
    if (!((ALU_LAT < (1 << CNT_W)) && (LD_LAT < (1 << CNT_W)) &&
          (LD_USE_STALL <= LD_LAT) && (CNT_W <= SB_CNT_MAX_W))) begin : g_cfg_err
        $error("hazard_scoreboard: illegal ALU_LAT/LD_LAT/LD_USE_STALL/CNT_W combination");
    end

    sb_entry_t w_entry [NREG];
    logic      w_src2_used;
    logic [1:0] w_hazard_src;
    logic      w_wr_en;

    // Register 0 is hard-wired to "no pending write"
    assign w_entry[0] = '0;

    assign w_src2_used = !is_imm || ST_or_BNE;

    // A pending write blocks a reader unless forwarding can cover it; loads
    // still stall while the data is too far from being forwardable.
    function automatic logic f_conflict(input logic [REG_ADDR_W-1:0] s,
                                        input sb_entry_t             e,
                                        input logic                  fwd);
        f_conflict = (s != '0) && (e.cnt != '0) &&
                     (!fwd || (e.ld && (e.cnt > SB_CNT_MAX_W'(LD_FWD_THR))));
    endfunction

    // Zero-latency source conflict detection, gated by a valid ID instruction
    always_comb begin
        w_hazard_src = '0;
        if (issue_valid) begin
            w_hazard_src[HSRC_SRC1] = f_conflict(src1_ID, w_entry[src1_ID], forward_EN);
            w_hazard_src[HSRC_SRC2] = w_src2_used &&
                                      f_conflict(src2_ID, w_entry[src2_ID], forward_EN);
        end
    end

    assign hazard_src      = w_hazard_src;
    assign hazard_detected = |w_hazard_src;
    assign issue_fire      = issue_valid && !hazard_detected && !flush && !rst;
    assign w_wr_en         = issue_fire && WB_EN_ID && (dest_ID != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic w_load;
        assign w_load = w_wr_en && (dest_ID == REG_ADDR_W'(r));

        sb_entry #(
            .CNT_W   (CNT_W),
            .ALU_LAT (ALU_LAT),
            .LD_LAT  (LD_LAT)
        ) u_sb_entry (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_is_ld (MEM_R_EN_ID),
            .o_entry (w_entry[r])
        );
    end

`ifdef HAZARD_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Count stalled cycles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (hazard_detected && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// stimulus, checked against a pending-write reference model via a queue.
module tb_hazard_scoreboard;

    localparam int unsigned RAW = 5;
    localparam int unsigned ALU = 2;
`ifdef HAZARD_STATS_EN
    localparam int unsigned LDL = 7;
`else
    localparam int unsigned LDL = 3;
`endif
    localparam int unsigned LUS = 1;
    localparam int unsigned CW  = 3;

    logic           clk;
    logic           rst;
    logic           issue_valid;
    logic [RAW-1:0] src1_ID, src2_ID, dest_ID;
    logic           is_imm, ST_or_BNE, WB_EN_ID, MEM_R_EN_ID, forward_EN, flush;
    logic           hazard_detected;
    logic [1:0]     hazard_src;
    logic           issue_fire;
    logic [15:0]    stall_cnt;

    hazard_scoreboard #(
        .REG_ADDR_W   (RAW),
        .ALU_LAT      (ALU),
        .LD_LAT       (LDL),
        .LD_USE_STALL (LUS),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .src1_ID         (src1_ID),
        .src2_ID         (src2_ID),
        .is_imm          (is_imm),
        .ST_or_BNE       (ST_or_BNE),
        .dest_ID         (dest_ID),
        .WB_EN_ID        (WB_EN_ID),
        .MEM_R_EN_ID     (MEM_R_EN_ID),
        .forward_EN      (forward_EN),
        .flush           (flush),
        .hazard_detected (hazard_detected),
        .hazard_src      (hazard_src),
        .issue_fire      (issue_fire),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic           rst;
        logic           valid;
        logic [RAW-1:0] s1;
        logic [RAW-1:0] s2;
        logic [RAW-1:0] dest;
        logic           imm;
        logic           stb;
        logic           wb;
        logic           ld;
        logic           fwd;
        logic           flush;
    } stim_t;

    typedef struct packed {
        logic [1:0]  hsrc;
        logic        hz;
        logic        fire;
        logic [15:0] stall;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model: remaining cycles until each register's write lands
    int    rem [32];
    bit    mld [32];
    int    m_stall;
    stim_t cur;

    function automatic bit m_conflict(input logic [RAW-1:0] r, input logic fwd);
        int idx;
        idx = int'(r);
        if (idx == 0 || rem[idx] == 0) return 1'b0;
        if (!fwd) return 1'b1;
        return mld[idx] && (rem[idx] > (int'(LDL) - int'(LUS)));
    endfunction

    function automatic logic [1:0] m_hsrc(input stim_t s);
        logic [1:0] h;
        h = 2'b00;
        if (s.valid && !s.rst) begin
            h[0] = m_conflict(s.s1, s.fwd);
            h[1] = (!s.imm || s.stb) && m_conflict(s.s2, s.fwd);
        end
        return h;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            rem[i] = 0;
            mld[i] = 1'b0;
        end
        m_stall = 0;
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle
    task automatic m_edge();
        bit hz, fire;
        if (cur.rst) begin
            m_clear();
            return;
        end
        hz   = (m_hsrc(cur) != 2'b00);
        fire = cur.valid && !hz && !cur.flush;
        for (int i = 0; i < 32; i++) if (rem[i] > 0) rem[i] = rem[i] - 1;
        if (fire && cur.wb && cur.dest != '0) begin
            rem[int'(cur.dest)] = cur.ld ? int'(LDL) : int'(ALU);
            mld[int'(cur.dest)] = cur.ld;
        end
`ifdef HAZARD_STATS_EN
        if (hz && m_stall < 65535) m_stall = m_stall + 1;
`endif
    endtask

    task automatic apply(input stim_t s);
        rst         = s.rst;
        issue_valid = s.valid;
        src1_ID     = s.s1;
        src2_ID     = s.s2;
        dest_ID     = s.dest;
        is_imm      = s.imm;
        ST_or_BNE   = s.stb;
        WB_EN_ID    = s.wb;
        MEM_R_EN_ID = s.ld;
        forward_EN  = s.fwd;
        flush       = s.flush;
    endtask

    // One cycle of stimulus: step the model past the edge, drive, queue expectation
    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        m_edge();
        #1;
        apply(s);
        cur = s;
        if (s.rst) m_clear();
        e.hsrc  = m_hsrc(s);
        e.hz    = (e.hsrc != 2'b00);
        e.fire  = s.valid && !e.hz && !s.flush && !s.rst;
        e.stall = 16'(m_stall);
        q.push_back(e);
    endtask

    function automatic stim_t mk(input logic v, input int s1, input int s2,
                                 input logic imm, input logic stb, input int d,
                                 input logic wb, input logic ld, input logic fwd);
        stim_t s;
        s.rst   = 1'b0;
        s.valid = v;
        s.s1    = RAW'(s1);
        s.s2    = RAW'(s2);
        s.dest  = RAW'(d);
        s.imm   = imm;
        s.stb   = stb;
        s.wb    = wb;
        s.ld    = ld;
        s.fwd   = fwd;
        s.flush = 1'b0;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT against each queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard_src",      16'(hazard_src),      16'(e.hsrc));
                chk("hazard_detected", 16'(hazard_detected), 16'(e.hz));
                chk("issue_fire",      16'(issue_fire),      16'(e.fire));
                chk("stall_cnt",       stall_cnt,            e.stall);
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #6_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        cur     = '0;
        cur.rst = 1'b1;
        apply(cur);
        m_clear();

        // Reset held with a valid instruction presented
        s = mk(1, 3, 3, 0, 0, 3, 1, 0, 1);
        s.rst = 1'b1;
        drive(s);
        drive(s);

        // No forwarding: ADD r3 then reader of r3 stalls two cycles
        drive(mk(1, 0, 0, 1, 0, 3, 1, 0, 0));
        repeat (3) drive(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));

        // Forwarding: LD r5 then src2 reader stalls once; ALU dependent never stalls
        drive(mk(1, 0, 0, 1, 0, 5, 1, 1, 1));
        repeat (2) drive(mk(1, 0, 5, 0, 0, 0, 0, 0, 1));
        drive(mk(1, 0, 0, 1, 0, 6, 1, 0, 1));
        repeat (2) drive(mk(1, 6, 6, 0, 0, 0, 0, 0, 1));

        // src2 usage gated by is_imm / ST_or_BNE
        drive(mk(1, 0, 0, 1, 0, 7, 1, 0, 0));
        drive(mk(1, 0, 7, 1, 0, 0, 0, 0, 0));
        drive(mk(1, 0, 7, 1, 1, 0, 0, 0, 0));

        // Register 0 never pending
        drive(mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        repeat (3) drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

        // WAW: ADD after LD to r4 leaves an ALU-type pending write
        drive(mk(1, 0, 0, 1, 0, 4, 1, 1, 1));
        drive(mk(1, 0, 0, 1, 0, 4, 1, 0, 1));
        drive(mk(1, 4, 4, 0, 0, 0, 0, 0, 1));
        drive(mk(1, 4, 0, 1, 0, 0, 0, 0, 0));

        // Flushed and stalled writers must not mark their destination
        s = mk(1, 0, 0, 1, 0, 8, 1, 1, 0);
        s.flush = 1'b1;
        drive(s);
        drive(mk(1, 8, 0, 1, 0, 0, 0, 0, 0));

        // Reset pulsed mid-countdown clears pending state without an edge
        drive(mk(1, 0, 0, 1, 0, 9, 1, 1, 0));
        drive(mk(1, 9, 0, 1, 0, 0, 0, 0, 0));
        s = mk(1, 9, 9, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        drive(mk(1, 9, 9, 0, 0, 0, 0, 0, 0));

        // Randomized traffic on a small register window to provoke conflicts
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.valid = ($urandom_range(0, 9) != 0);
            s.s1    = RAW'($urandom_range(0, 7));
            s.s2    = RAW'($urandom_range(0, 7));
            s.dest  = RAW'($urandom_range(0, 7));
            s.imm   = 1'($urandom);
            s.stb   = 1'($urandom);
            s.wb    = ($urandom_range(0, 3) != 0);
            s.ld    = 1'($urandom);
            s.fwd   = ($urandom_range(0, 3) != 0);
            s.flush = ($urandom_range(0, 9) == 0);
            drive(s);
        end

`ifdef HAZARD_STATS_EN
        // Stall counter: a few hazards, then enough to saturate
        s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        drive(mk(1, 0, 0, 1, 0, 10, 1, 1, 0));
        repeat (3) drive(mk(1, 10, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 9400; i++) begin
            drive(mk(1, 0, 0, 1, 0, 10, 1, 1, 0));
            repeat (LDL) drive(mk(1, 10, 0, 1, 0, 0, 0, 0, 0));
        end
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
`endif

        // Drain the expectation queue within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be: REG_ADDR_W, default 5, register address width; ALU_LAT, default 2, cycles from issue to register-file write for ALU ops; LD_LAT, default 3, the same for loads; LD_USE_STALL, default 1, load-use stall cycles with forwarding; CNT_W, default 3, countdown width.
REQ-002 clk  in  1  single clock; rising edge active.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 issue_valid  in  1  ID holds an instruction requesting issue.
REQ-005 src1_ID, src2_ID  in  REG_ADDR_W each  ID source registers.
REQ-006 is_imm, ST_or_BNE  in  1 each  src2 is used iff (!is_imm || ST_or_BNE).
REQ-007 dest_ID  in  REG_ADDR_W  ID destination register.
REQ-008 WB_EN_ID, MEM_R_EN_ID  in  1 each  ID instruction writes back / is a load.
REQ-009 forward_EN  in  1  forwarding network enabled.
REQ-010 flush  in  1  squash the ID instruction this cycle.
REQ-011 hazard_detected  out  1  stall ID this cycle.
REQ-012 hazard_src  out  2  bit0 = src1 conflict, bit1 = src2 conflict.
REQ-013 issue_fire  out  1  issue_valid && !hazard_detected && !flush.
REQ-014 stall_cnt  out  16  stall-cycle count (see Configuration).

Function
REQ-015 Per register r, state SHALL be cnt[r] (CNT_W bits) and ld[r] (1 bit); cnt[r]==0 means no pending write.
REQ-016 Every clock edge, each nonzero cnt[r] SHALL decrement by 1, saturating at 0.
REQ-017 On issue_fire && WB_EN_ID && dest_ID!=0: cnt[dest_ID] <= MEM_R_EN_ID ? LD_LAT : ALU_LAT; ld[dest_ID] <= MEM_R_EN_ID. Loading a new count overrides the decrement (WAW: newest write wins).
REQ-018 Register 0 SHALL never be marked pending and SHALL never cause a hazard.
REQ-019 Source s conflicts iff s!=0, s is used (src1 always; src2 per REQ-006), cnt[s]!=0, and either forward_EN==0, or ld[s] && cnt[s] > LD_LAT-LD_USE_STALL.
REQ-020 hazard_src and hazard_detected (OR of hazard_src) SHALL be combinational from current state and inputs, with zero latency, and SHALL be gated by issue_valid.
REQ-021 No scoreboard update SHALL occur on flush or hazard_detected; decrement continues.
REQ-022 Elaboration SHALL fail unless max(ALU_LAT, LD_LAT) < 2**CNT_W and LD_USE_STALL <= LD_LAT.

Reset
REQ-023 While rst is high, all cnt, all ld and stall_cnt SHALL be 0; hazard_detected, hazard_src and issue_fire SHALL therefore be 0.
REQ-024 Reset asserted mid-operation SHALL discard all pending entries immediately, with no clock edge needed.

Configuration
REQ-025 With HAZARD_STATS_EN defined, stall_cnt SHALL increment on every clock where hazard_detected==1 and saturate at 16'hFFFF.
REQ-026 Without HAZARD_STATS_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Structure
REQ-027 The shared package SHALL hold the parameter defaults, the hazard_src bit positions and the scoreboard entry struct {cnt, ld}.
REQ-028 The per-register countdown SHALL be one sub-module, sb_entry, instantiated 2**REG_ADDR_W-1 times (register 0 excluded).

Verification
REQ-029 forward_EN=0: issue ADD dest=3, then next cycle src1=3 -> hazard_detected=1 for 2 cycles (cnt 2, then 1), 0 on the third.
REQ-030 forward_EN=1: issue LD dest=5, then next cycle src2=5 with is_imm=0 -> exactly 1 stall cycle with hazard_src=2'b10; a dependent ALU op after ADD -> 0 stalls.
REQ-031 src2=7 pending, is_imm=1, ST_or_BNE=0 -> no hazard; same with ST_or_BNE=1 -> hazard.
REQ-032 Issue dest=0 with WB_EN_ID=1, then src1=0 -> hazard_detected never asserts.
REQ-033 LD dest=4 then ADD dest=4 on consecutive cycles (forwarding on) -> cnt[4]=ALU_LAT, ld[4]=0 after the second issue; rst pulsed mid-countdown -> all hazards clear asynchronously.
REQ-034 HAZARD_STATS_EN defined: 3 hazard cycles -> stall_cnt=3; forced 65,540 hazard cycles -> stall_cnt=16'hFFFF.
